// File: rtl/priv_ext_csr_master.sv
// Initiator for the privilege-extension CSR port: turns one READ/RW/RS/RC request into a
// read, optional single-cycle write strobe and optional verify readback toward the responders.
module priv_ext_csr_master #(
  parameter int unsigned ACK_TIMEOUT   = 4,
  parameter bit          VERIFY_WRITES = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  // request side (CSR decode stage)
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_wdata,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_warl,
  // responder port
  output logic        csr_active,
  output logic [11:0] csr_addr,
  output logic [31:0] value_in,
  input  logic [31:0] value_out,
  input  logic        ack,
  input  logic        invalid_csr
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] VFY  = 3'd3;
  localparam logic [2:0] RSP  = 3'd4;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_RW   = 2'd1;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(ACK_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] new_q, new_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        warl_q, warl_d;

  logic [31:0] rmw_val;
  logic        wr_needed;

  // Read-modify-write result computed from the live read data during RD.
  always_comb begin
    rmw_val = value_out;
    case (op_q)
      OP_READ: rmw_val = value_out;
      OP_RW:   rmw_val = wdata_q;
      OP_RS:   rmw_val = value_out | wdata_q;
      OP_RC:   rmw_val = value_out & ~wdata_q;
      default: rmw_val = value_out;
    endcase
  end

  // Set/clear with an empty mask is a pure read and must not disturb the responder.
  assign wr_needed = (op_q == OP_RW) ||
                     (((op_q == OP_RS) || (op_q == OP_RC)) && (wdata_q != 32'h0));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    new_d   = new_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    warl_d  = warl_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          op_d    = req_op;
          wdata_d = req_wdata;
          old_d   = 32'h0;
          new_d   = 32'h0;
          cnt_d   = 4'h0;
          err_d   = 1'b0;
          warl_d  = 1'b0;
          state_d = RD;
        end
      end

      RD: begin
        if (ack) begin
          cnt_d = 4'h0;
          if (invalid_csr) begin
            err_d   = 1'b1;
            old_d   = 32'h0;
            state_d = RSP;
          end else begin
            old_d   = value_out;
            new_d   = rmw_val;
            state_d = wr_needed ? WR : RSP;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          old_d   = 32'h0;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 4'h1;
        end
      end

      WR: begin
        cnt_d   = 4'h0;
        state_d = VERIFY_WRITES ? VFY : RSP;
      end

      VFY: begin
        if (ack) begin
          warl_d  = (value_out != new_q);
          state_d = RSP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          warl_d  = 1'b0;
          old_d   = 32'h0;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 4'h1;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= 12'h0;
      op_q    <= OP_READ;
      wdata_q <= 32'h0;
      old_q   <= 32'h0;
      new_q   <= 32'h0;
      cnt_q   <= 4'h0;
      err_q   <= 1'b0;
      warl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      new_q   <= new_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      warl_q  <= warl_d;
    end
  end

  // Responder-facing outputs decode straight from state so value_out/ack settle in-cycle.
  always_comb begin
    req_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == RSP);
    rsp_rdata  = old_q;
    rsp_err    = err_q;
    rsp_warl   = warl_q;
    csr_active = (state_q == WR);
    csr_addr   = 12'h0;
    value_in   = 32'h0;
    if ((state_q == RD) || (state_q == WR) || (state_q == VFY)) begin
      csr_addr = addr_q;
    end
    if (state_q == WR) begin
      value_in = new_q;
    end
  end

endmodule

// File: tb/tb_priv_ext_csr_master.sv
// Directed bench for priv_ext_csr_master with a small PMP-like responder model.
module tb_priv_ext_csr_master;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_RW   = 2'd1;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = 12'h0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_warl;
  logic        csr_active;
  logic [11:0] csr_addr;
  logic [31:0] value_in;
  logic [31:0] value_out;
  logic        ack;
  logic        invalid_csr;

  int n_checks = 0;
  int n_err    = 0;

  priv_ext_csr_master #(.ACK_TIMEOUT(4), .VERIFY_WRITES(1'b1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_op     (req_op),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_warl   (rsp_warl),
    .csr_active (csr_active),
    .csr_addr   (csr_addr),
    .value_in   (value_in),
    .value_out  (value_out),
    .ack        (ack),
    .invalid_csr(invalid_csr)
  );

  always #5 CLK = ~CLK;

  // Responder model: 0x3A0 cfg (W without R reads back 0), 0x3B0/0x3B1 plain, 0x3B2 locked,
  // 0x3C0 claimed but invalid, everything else unclaimed.
  logic [31:0] r_cfg0, r_addr0, r_addr1, r_lock;
  logic        ack_en = 1'b1;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = 12'h0;
  logic [31:0] pre_val = 32'h0;

  always @(posedge CLK) begin
    if (csr_active) begin
      case (csr_addr)
        12'h3A0: r_cfg0 <= (value_in[1] && !value_in[0]) ? 32'h0 : value_in;
        12'h3B0: r_addr0 <= value_in;
        12'h3B1: r_addr1 <= value_in;
        default: ;
      endcase
    end else if (pre_en) begin
      case (pre_addr)
        12'h3A0: r_cfg0 <= pre_val;
        12'h3B0: r_addr0 <= pre_val;
        12'h3B1: r_addr1 <= pre_val;
        12'h3B2: r_lock <= pre_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    value_out   = 32'h0;
    ack         = 1'b0;
    invalid_csr = 1'b0;
    case (csr_addr)
      12'h3A0: begin value_out = r_cfg0;  ack = ack_en; end
      12'h3B0: begin value_out = r_addr0; ack = ack_en; end
      12'h3B1: begin value_out = r_addr1; ack = ack_en; end
      12'h3B2: begin value_out = r_lock;  ack = ack_en; end
      12'h3C0: begin ack = ack_en; invalid_csr = 1'b1; end
      default: ;
    endcase
  end

  function automatic logic [31:0] read_model(input logic [11:0] a);
    case (a)
      12'h3A0: return r_cfg0;
      12'h3B0: return r_addr0;
      12'h3B1: return r_addr1;
      12'h3B2: return r_lock;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] rdata;
    logic        err;
    logic        warl;
    logic        wr;
    logic [31:0] wval;
    int          lat;
    logic        chk_final;
    logic [31:0] final_v;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [31:0] init,
                              input logic [31:0] rdata, input logic err, input logic warl,
                              input logic wr, input logic [31:0] wval, input int lat,
                              input logic chk_final, input logic [31:0] final_v);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.init = init; v.rdata = rdata;
    v.err = err; v.warl = warl; v.wr = wr; v.wval = wval; v.lat = lat;
    v.chk_final = chk_final; v.final_v = final_v;
    return v;
  endfunction

  // Preload the target register, present the request, leave time at #1 after the accept edge.
  task automatic start_req(input string tag, input logic [11:0] addr, input logic [1:0] op,
                           input logic [31:0] wdata, input logic [31:0] init);
    pre_en = 1'b1; pre_addr = addr; pre_val = init;
    @(posedge CLK); #1;
    pre_en    = 1'b0;
    req_valid = 1'b1; req_addr = addr; req_op = op; req_wdata = wdata;
    check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  // Walk cycles until rsp_valid, counting write strobes and watching the port between strobes.
  task automatic wait_rsp(input string tag, input logic [11:0] addr, input int lat0,
                          output int lat, output int nwr, output logic [31:0] wval);
    bit done = 0;
    lat = lat0; nwr = 0; wval = 32'h0;
    while (!done && lat < 40) begin
      if (csr_active) begin
        nwr++;
        wval = value_in;
      end else begin
        check({tag, "_value_in_idle"}, value_in, 32'h0);
      end
      if (rsp_valid) begin
        done = 1;
      end else begin
        check({tag, "_csr_addr"}, 32'(csr_addr), 32'(addr));
        check({tag, "_req_ready_busy"}, 32'(req_ready), 32'h0);
        @(posedge CLK); #1;
        lat++;
      end
    end
    check({tag, "_rsp_seen"}, 32'(done), 32'h1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, nwr;
    logic [31:0] wval;
    string tag = $sformatf("v%0d", idx);
    rsp_ready = 1'b1;
    start_req(tag, v.addr, v.op, v.wdata, v.init);
    wait_rsp(tag, v.addr, 1, lat, nwr, wval);
    check({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check({tag, "_nwrites"}, 32'(nwr), v.wr ? 32'h1 : 32'h0);
    if (v.wr) check({tag, "_value_in"}, wval, v.wval);
    check({tag, "_rdata"}, rsp_rdata, v.rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(v.err));
    check({tag, "_warl"}, 32'(rsp_warl), 32'(v.warl));
    @(posedge CLK); #1;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'h0);
    check({tag, "_req_ready_back"}, 32'(req_ready), 32'h1);
    if (v.chk_final) check({tag, "_final"}, read_model(v.addr), v.final_v);
  endtask

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, nwr;
    logic [31:0] wval;

    //       op       addr     wdata         init          rdata        e  w  wr wval  lat chk final
    vt[0]  = mk(OP_RW,   12'h3A0, 32'h3,        32'h0,        32'h0,        0, 0, 1, 32'h3, 4, 1, 32'h3);
    vt[1]  = mk(OP_RW,   12'h3A0, 32'h2,        32'h0,        32'h0,        0, 1, 1, 32'h2, 4, 1, 32'h0);
    vt[2]  = mk(OP_RS,   12'h3B0, 32'h0,        32'h1234,     32'h1234,     0, 0, 0, 32'h0, 2, 1, 32'h1234);
    vt[3]  = mk(OP_READ, 12'h7C0, 32'h0,        32'h0,        32'h0,        1, 0, 0, 32'h0, 5, 0, 32'h0);
    vt[4]  = mk(OP_RC,   12'h3B1, 32'hF,        32'hFF,       32'hFF,       0, 0, 1, 32'hF0, 4, 1, 32'hF0);
    vt[5]  = mk(OP_RS,   12'h3B1, 32'hF00,      32'h0F,       32'h0F,       0, 0, 1, 32'hF0F, 4, 1, 32'hF0F);
    vt[6]  = mk(OP_READ, 12'h3B0, 32'hFFFF,     32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 32'h0, 2, 1,
                32'hDEADBEEF);
    vt[7]  = mk(OP_RC,   12'h3B0, 32'h0,        32'h55,       32'h55,       0, 0, 0, 32'h0, 2, 1, 32'h55);
    vt[8]  = mk(OP_RW,   12'h3C0, 32'h1,        32'h0,        32'h0,        1, 0, 0, 32'h0, 2, 0, 32'h0);
    vt[9]  = mk(OP_RW,   12'h3B2, 32'hAAAA,     32'h5,        32'h5,        0, 1, 1, 32'hAAAA, 4, 1, 32'h5);
    vt[10] = mk(OP_RW,   12'h3B0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 4, 1, 32'h0);
    vt[11] = mk(OP_RS,   12'h3B0, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 0, 0, 1, 32'hFFFFFFFF, 4, 1,
                32'hFFFFFFFF);

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_rsp_warl", 32'(rsp_warl), 32'h0);
    check("rst_csr_active", 32'(csr_active), 32'h0);
    check("rst_csr_addr", 32'(csr_addr), 32'h0);
    check("rst_value_in", value_in, 32'h0);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // Response back-pressure: rsp_valid and data must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    start_req("bp", 12'h3B1, OP_RC, 32'hF, 32'hFF);
    wait_rsp("bp", 12'h3B1, 1, lat, nwr, wval);
    check("bp_latency", 32'(lat), 32'd4);
    check("bp_value_in", wval, 32'hF0);
    check("bp_rdata0", rsp_rdata, 32'hFF);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'h1);
      check("bp_hold_rdata", rsp_rdata, 32'hFF);
      check("bp_hold_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_release_valid", 32'(rsp_valid), 32'h0);
    check("bp_release_req_ready", 32'(req_ready), 32'h1);
    check("bp_final", read_model(12'h3B1), 32'hF0);

    // Ack arriving in the last allowed RD cycle must still be taken.
    ack_en = 1'b0;
    start_req("late", 12'h3B0, OP_READ, 32'h0, 32'h42);
    repeat (3) begin @(posedge CLK); #1; end
    ack_en = 1'b1;
    wait_rsp("late", 12'h3B0, 4, lat, nwr, wval);
    check("late_latency", 32'(lat), 32'd5);
    check("late_err", 32'(rsp_err), 32'h0);
    check("late_rdata", rsp_rdata, 32'h42);
    @(posedge CLK); #1;

    // Verify readback that never gets acked: error, no warl, zero data, single write.
    start_req("vto", 12'h3B0, OP_RW, 32'h9, 32'h1);
    @(posedge CLK); #1;
    check("vto_wr_strobe", 32'(csr_active), 32'h1);
    ack_en = 1'b0;
    wait_rsp("vto", 12'h3B0, 2, lat, nwr, wval);
    check("vto_latency", 32'(lat), 32'd7);
    check("vto_nwrites", 32'(nwr), 32'h1);
    check("vto_err", 32'(rsp_err), 32'h1);
    check("vto_warl", 32'(rsp_warl), 32'h0);
    check("vto_rdata", rsp_rdata, 32'h0);
    check("vto_final", read_model(12'h3B0), 32'h9);
    ack_en = 1'b1;
    @(posedge CLK); #1;

    // Reset asserted in the WR cycle aborts the transaction.
    start_req("rst", 12'h3B0, OP_RW, 32'h77, 32'h11);
    @(posedge CLK); #1;
    check("rstwr_in_wr", 32'(csr_active), 32'h1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rstwr_csr_active", 32'(csr_active), 32'h0);
    check("rstwr_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rstwr_req_ready", 32'(req_ready), 32'h1);
    check("rstwr_csr_addr", 32'(csr_addr), 32'h0);
    RST = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      check("rstwr_no_strobe", 32'(csr_active), 32'h0);
      check("rstwr_no_rsp", 32'(rsp_valid), 32'h0);
    end
    run_vec(vt[6], 99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
